watch_set_ctrl: RTL and testbench
=================================

Name: watch_set_ctrl

Overview:
Time-setting controller for the 24-hour watch counter. It turns debounced mode/increment/decrement button pulses into an edit sequence (hour -> minute -> second), holds the edited time in shadow registers, and drives the watch's parallel-load interface (set_watch, bin_watch). It gates the 1 Hz run enable while editing and aborts editing after an inactivity timeout. It sits between the button front-end and the watch counter, and feeds the display mux.

Parameters:
TIMEOUT_S, 10, number of tick_1hz pulses without button activity before an edit is aborted (range 1..31)
TO_W, 5, width of the inactivity counter; must hold TIMEOUT_S

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
tick_1hz  input  1  one-cycle 1 Hz enable pulse
btn_mode  input  1  one-cycle pulse, already debounced and synchronised
btn_inc  input  1  one-cycle pulse, increment the selected field
btn_dec  input  1  one-cycle pulse, decrement the selected field
cur_hour  input  5  live hour from the watch (0..23)
cur_min  input  6  live minute from the watch (0..59)
cur_sec  input  6  live second from the watch (0..59)
run_en  output  1  1 Hz enable forwarded to the watch = tick_1hz AND state==RUN AND !set_watch
set_watch  output  1  one-cycle load strobe to the watch
bin_watch  output  17  {hour[16:12], min[11:6], sec[5:0]}, driven directly from the shadow registers
mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC (state encoding)
blink  output  1  display blink phase for the selected field

Behaviour:
- Reset (async, rst=0): state=RUN. Shadow hour/min/sec=0, so bin_watch=0. set_watch=0, blink=0, inactivity counter=0. mode=0. run_en follows its equation (0 unless tick_1hz).
- All other state updates occur on the rising edge of clk.
- RUN:
  - btn_mode=1: capture cur_hour/cur_min/cur_sec into the shadow registers; state->SET_HOUR; counter=0; blink=1.
  - Any captured value out of range (hour>23, min/sec>59) is stored as 0.
  - btn_inc and btn_dec are ignored. blink=0.
- SET_HOUR / SET_MIN / SET_SEC:
  - btn_mode takes priority over inc/dec in the same cycle; the inc/dec is dropped.
  - SET_HOUR + btn_mode -> SET_MIN. SET_MIN + btn_mode -> SET_SEC.
  - SET_SEC + btn_mode -> RUN with set_watch=1 on the next cycle (registered). bin_watch holds the shadow value during that cycle. set_watch returns to 0 the following cycle.
  - btn_inc only: selected field +1, wrapping 23->0 (hour) or 59->0 (min/sec).
  - btn_dec only: selected field -1, wrapping 0->23 (hour) or 0->59 (min/sec).
  - btn_inc and btn_dec together: field unchanged, but the press counts as activity.
  - Unselected fields never change.
- Blink: any button pulse sets blink=1 and clears the counter. Otherwise tick_1hz toggles blink and increments the counter.
- Timeout: a tick_1hz arriving while counter==TIMEOUT_S-1 (with no button that cycle) aborts the edit. state->RUN, set_watch stays 0, shadow registers are left as-is, blink=0, counter=0. Button and tick in the same cycle: the button wins and the counter is cleared.
- run_en is 0 in every set state and in the set_watch cycle, so a load never coincides with a count. Time does not advance while editing.
- Reset mid-edit: immediate return to RUN with no load strobe.
- Latency: button to shadow/bin_watch change is 1 cycle; final btn_mode to set_watch is 1 cycle.

Test Plan:
1. Reset, then cur=13:45:30, pulse btn_mode -> mode=1, bin_watch={13,45,30}, run_en=0 even on tick_1hz, blink=1.
2. In SET_HOUR with hour=23, btn_inc -> hour=0. Then btn_dec twice -> 22. Move to SET_MIN with min=0, btn_dec -> 59; sec field unchanged throughout.
3. Full edit to 07:08:09, then btn_mode in SET_SEC -> exactly one set_watch pulse with bin_watch={7,8,9}, mode=0, run_en=0 that cycle, then run_en follows tick_1hz.
4. Enter SET_MIN and apply 10 tick_1hz pulses with no buttons -> mode=0 after the 10th tick, no set_watch; blink toggles on ticks 1..9.
5. btn_mode+btn_inc in the same cycle in SET_HOUR -> SET_MIN, hour unchanged. btn_inc+btn_dec together at tick 9 -> counter cleared, no abort at tick 10.
6. Assert rst low during SET_SEC with shadow={5,6,7} -> mode=0, bin_watch=0, set_watch=0 immediately, without waiting for clk. Also drive cur_hour=30 at capture -> shadow hour=0.

Source files
------------

// File: rtl/watch_set_ctrl_if.sv
//------------------------------------------------------------------------------
// watch_set_ctrl_if
//
// Bundles the button front-end inputs, the live time from the watch counter
// and the controller's outputs (run enable, parallel-load strobe and value,
// mode and blink for the display mux).
//
//   tick_1hz   1 Hz enable pulse                    (master -> slave)
//   btn_mode   mode button pulse                    (master -> slave)
//   btn_inc    increment button pulse               (master -> slave)
//   btn_dec    decrement button pulse               (master -> slave)
//   cur_hour   live hour   0..23                    (master -> slave)
//   cur_min    live minute 0..59                    (master -> slave)
//   cur_sec    live second 0..59                    (master -> slave)
//   run_en     gated 1 Hz enable to the watch       (slave -> master)
//   set_watch  one-cycle load strobe                (slave -> master)
//   bin_watch  {hour[16:12], min[11:6], sec[5:0]}   (slave -> master)
//   mode       0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC (slave -> master)
//   blink      blink phase of the selected field    (slave -> master)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface watch_set_ctrl_if;
   logic        tick_1hz;
   logic        btn_mode;
   logic        btn_inc;
   logic        btn_dec;
   logic [4:0]  cur_hour;
   logic [5:0]  cur_min;
   logic [5:0]  cur_sec;
   logic        run_en;
   logic        set_watch;
   logic [16:0] bin_watch;
   logic [1:0]  mode;
   logic        blink;

   modport master (
      output tick_1hz, btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
      input  run_en, set_watch, bin_watch, mode, blink
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
      output run_en, set_watch, bin_watch, mode, blink
   );
endinterface

// File: rtl/watch_set_ctrl.sv
//------------------------------------------------------------------------------
// watch_set_ctrl
//
// Time-setting controller for the 24-hour watch counter. A mode press in RUN
// snapshots the live time into shadow registers and walks the edit sequence
// hour -> minute -> second; inc/dec adjust the selected field with wrap-around.
// The mode press in SET_SEC returns to RUN and issues a one-cycle load strobe
// with the shadow value on bin_watch. Editing is abandoned without a load after
// TIMEOUT_S ticks of button inactivity. The 1 Hz enable to the watch is gated
// off while editing and during the load cycle.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   watch_set_ctrl_if.slave (buttons, tick, live time in;
//         run_en, set_watch, bin_watch, mode, blink out)
//
// Parameters:
//   TIMEOUT_S  inactivity ticks before an edit is aborted (1..31)
//   TO_W       width of the inactivity counter
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module watch_set_ctrl #(
   parameter int unsigned TIMEOUT_S = 10,
   parameter int unsigned TO_W      = 5
) (
   input  logic               clk,
   input  logic               rst,
   watch_set_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } state_t;

   localparam logic [5:0]      HOUR_MAX = 6'd23;
   localparam logic [5:0]      MS_MAX   = 6'd59;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_S - 1);

   state_t          state_q, state_d;
   logic [4:0]      hour_q,  hour_d;
   logic [5:0]      min_q,   min_d;
   logic [5:0]      sec_q,   sec_d;
   logic            set_q,   set_d;
   logic            blink_q, blink_d;
   logic [TO_W-1:0] cnt_q,   cnt_d;

   logic            btn_any;
   logic            step_up;
   logic            step_dn;

   // One step up or down with wrap at [0, top]; shared by all three fields.
   function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                            input logic [5:0] top,
                                            input logic       up);
      logic [5:0] r;
      if (up) begin
         r = (v >= top) ? 6'd0 : v + 6'd1;
      end else begin
         r = (v == 6'd0) ? top : v - 6'd1;
      end
      return r;
   endfunction

   assign btn_any = bus.btn_mode | bus.btn_inc | bus.btn_dec;
   assign step_up = bus.btn_inc & ~bus.btn_dec;
   assign step_dn = bus.btn_dec & ~bus.btn_inc;

   //---------------------------------------------------------------------------
   // State and shadow registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         set_q   <= 1'b0;
         blink_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         set_q   <= set_d;
         blink_q <= blink_d;
         cnt_q   <= cnt_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      set_d   = 1'b0;
      blink_d = blink_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         RUN: begin
            blink_d = 1'b0;
            cnt_d   = '0;
            if (bus.btn_mode) begin
               // Out-of-range live values are sanitised to 0 on capture.
               hour_d  = (bus.cur_hour > 5'd23) ? 5'd0 : bus.cur_hour;
               min_d   = (bus.cur_min  > MS_MAX) ? 6'd0 : bus.cur_min;
               sec_d   = (bus.cur_sec  > MS_MAX) ? 6'd0 : bus.cur_sec;
               state_d = SET_HOUR;
               blink_d = 1'b1;
            end
         end

         default: begin
            if (bus.btn_mode) begin
               // Mode wins over a simultaneous inc/dec, which is dropped.
               cnt_d = '0;
               unique case (state_q)
                  SET_HOUR: begin
                     state_d = SET_MIN;
                     blink_d = 1'b1;
                  end
                  SET_MIN: begin
                     state_d = SET_SEC;
                     blink_d = 1'b1;
                  end
                  default: begin
                     state_d = RUN;
                     set_d   = 1'b1;
                     blink_d = 1'b0;
                  end
               endcase
            end else if (btn_any) begin
               // inc+dec together leaves the field alone but still counts as activity.
               blink_d = 1'b1;
               cnt_d   = '0;
               if (step_up || step_dn) begin
                  unique case (state_q)
                     SET_HOUR: hour_d = 5'(wrap_step({1'b0, hour_q}, HOUR_MAX, step_up));
                     SET_MIN:  min_d  = wrap_step(min_q, MS_MAX, step_up);
                     default:  sec_d  = wrap_step(sec_q, MS_MAX, step_up);
                  endcase
               end
            end else if (bus.tick_1hz) begin
               if (cnt_q == TO_LAST) begin
                  // Inactivity abort: back to RUN, no load, shadow kept.
                  state_d = RUN;
                  blink_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  blink_d = ~blink_q;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   // set_q blocks the count in the load cycle so load and count never collide.
   assign bus.run_en    = bus.tick_1hz & (state_q == RUN) & ~set_q;
   assign bus.set_watch = set_q;
   assign bus.bin_watch = {hour_q, min_q, sec_q};
   assign bus.mode      = state_q;
   assign bus.blink     = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
//------------------------------------------------------------------------------
// tb_watch_set_ctrl
//
// Directed scenarios followed by randomized stimulus, all checked against a
// behavioural model of the time-setting controller kept in this bench.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_watch_set_ctrl;

   localparam int unsigned TIMEOUT_S = 10;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   watch_set_ctrl_if bus();

   watch_set_ctrl #(
      .TIMEOUT_S(TIMEOUT_S),
      .TO_W     (5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model: mode number, fields as plain integers, idle tick count.
   int m_mode;
   int m_fld[3];
   int m_idle;
   int m_blink;
   int m_setw;
   int lim[3] = '{24, 60, 60};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_fld   = '{0, 0, 0};
      m_idle  = 0;
      m_blink = 0;
      m_setw  = 0;
   endtask

   task automatic model_step(input int tick, input int bm, input int bi, input int bd,
                             input int ch, input int cm, input int cs);
      int nset;
      nset = 0;
      if (m_mode == 0) begin
         m_blink = 0;
         m_idle  = 0;
         if (bm != 0) begin
            m_fld[0] = (ch > 23) ? 0 : ch;
            m_fld[1] = (cm > 59) ? 0 : cm;
            m_fld[2] = (cs > 59) ? 0 : cs;
            m_mode   = 1;
            m_blink  = 1;
         end
      end else if (bm != 0) begin
         m_idle = 0;
         if (m_mode == 3) begin
            m_mode  = 0;
            nset    = 1;
            m_blink = 0;
         end else begin
            m_mode  = m_mode + 1;
            m_blink = 1;
         end
      end else if (bi != 0 || bd != 0) begin
         int k;
         k = m_mode - 1;
         if (bi != 0 && bd == 0) m_fld[k] = (m_fld[k] + 1) % lim[k];
         if (bd != 0 && bi == 0) m_fld[k] = (m_fld[k] + lim[k] - 1) % lim[k];
         m_blink = 1;
         m_idle  = 0;
      end else if (tick != 0) begin
         m_idle = m_idle + 1;
         if (m_idle >= TIMEOUT_S) begin
            m_mode  = 0;
            m_blink = 0;
            m_idle  = 0;
         end else begin
            m_blink = 1 - m_blink;
         end
      end
      m_setw = nset;
   endtask

   task automatic check_outputs(input string where);
      chk({where, ".mode"},      32'(bus.mode),      32'(m_mode));
      chk({where, ".bin_watch"}, 32'(bus.bin_watch), 32'(m_fld[0] * 4096 + m_fld[1] * 64 + m_fld[2]));
      chk({where, ".set_watch"}, 32'(bus.set_watch), 32'(m_setw));
      chk({where, ".blink"},     32'(bus.blink),     32'(m_blink));
   endtask

   // One clock cycle: called 1 time unit after a rising edge.
   task automatic cycle(input int tick, input int bm, input int bi, input int bd,
                        input int ch = 0, input int cm = 0, input int cs = 0);
      bus.tick_1hz = tick[0];
      bus.btn_mode = bm[0];
      bus.btn_inc  = bi[0];
      bus.btn_dec  = bd[0];
      bus.cur_hour = 5'(ch);
      bus.cur_min  = 6'(cm);
      bus.cur_sec  = 6'(cs);
      #1;
      chk("run_en", 32'(bus.run_en), 32'((tick != 0 && m_mode == 0 && m_setw == 0) ? 1 : 0));
      model_step(tick, bm, bi, bd, ch, cm, cs);
      @(posedge clk);
      #1;
      check_outputs("cyc");
   endtask

   // Asynchronous reset, checked before any clock edge can occur.
   task automatic do_reset();
      bus.tick_1hz = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs("rst");
      chk("rst.run_en", 32'(bus.run_en), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst          = 1'b0;
      bus.tick_1hz = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
      bus.cur_hour = '0;
      bus.cur_min  = '0;
      bus.cur_sec  = '0;
      model_reset();
      #1;
      check_outputs("por");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // 1: capture 13:45:30, run_en gated while editing
      cycle(0, 1, 0, 0, 13, 45, 30);
      chk("t1.mode", 32'(bus.mode), 32'd1);
      chk("t1.bin", 32'(bus.bin_watch), {15'd0, 5'd13, 6'd45, 6'd30});
      chk("t1.blink", 32'(bus.blink), 32'd1);
      cycle(1, 0, 0, 0);

      // 2: hour wrap up/down, minute wrap down, second untouched
      do_reset();
      cycle(0, 1, 0, 0, 23, 0, 17);
      cycle(0, 0, 1, 0);
      chk("t2.hour_wrap", 32'(bus.bin_watch[16:12]), 32'd0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("t2.hour_dec", 32'(bus.bin_watch[16:12]), 32'd22);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1);
      chk("t2.min_wrap", 32'(bus.bin_watch), {15'd0, 5'd22, 6'd59, 6'd17});

      // 3: full edit to 07:08:09 and a single load strobe
      do_reset();
      cycle(0, 1, 0, 0, 5, 10, 9);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 1, 0, 0);
      chk("t3.set", 32'(bus.set_watch), 32'd1);
      chk("t3.bin", 32'(bus.bin_watch), {15'd0, 5'd7, 6'd8, 6'd9});
      chk("t3.mode", 32'(bus.mode), 32'd0);
      pulses = 1;
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 0, 0);
         if (bus.set_watch === 1'b1) pulses++;
      end
      chk("t3.pulses", 32'(pulses), 32'd1);

      // 4: inactivity timeout in SET_MIN
      do_reset();
      cycle(0, 1, 0, 0, 1, 2, 3);
      cycle(0, 1, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         cycle(1, 0, 0, 0);
         chk("t4.still_min", 32'(bus.mode), 32'd2);
      end
      cycle(1, 0, 0, 0);
      chk("t4.abort_mode", 32'(bus.mode), 32'd0);
      chk("t4.abort_set", 32'(bus.set_watch), 32'd0);
      chk("t4.shadow_kept", 32'(bus.bin_watch), {15'd0, 5'd1, 6'd2, 6'd3});

      // 5: mode beats inc; inc+dec at tick 9 restarts the idle count
      do_reset();
      cycle(0, 1, 0, 0, 1, 2, 3);
      cycle(0, 1, 1, 0);
      chk("t5.mode", 32'(bus.mode), 32'd2);
      chk("t5.hour", 32'(bus.bin_watch[16:12]), 32'd1);
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 1);
      chk("t5.min_same", 32'(bus.bin_watch[11:6]), 32'd2);
      for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);
      chk("t5.no_abort", 32'(bus.mode), 32'd2);
      cycle(1, 0, 0, 0);
      chk("t5.abort", 32'(bus.mode), 32'd0);

      // 6: out-of-range capture, then async reset in SET_SEC
      do_reset();
      cycle(0, 1, 0, 0, 30, 6, 7);
      chk("t6.hour_sanit", 32'(bus.bin_watch[16:12]), 32'd0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      chk("t6.pre_rst", 32'(bus.bin_watch), {15'd0, 5'd5, 6'd6, 6'd7});
      do_reset();

      // Random: busy buttons, including out-of-range live values
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(499) == 0) begin
            do_reset();
         end else begin
            cycle(($urandom_range(3) == 0) ? 1 : 0,
                  ($urandom_range(7) == 0) ? 1 : 0,
                  ($urandom_range(5) == 0) ? 1 : 0,
                  ($urandom_range(5) == 0) ? 1 : 0,
                  int'($urandom_range(31)), int'($urandom_range(63)),
                  int'($urandom_range(63)));
         end
      end

      // Random: sparse buttons, frequent ticks, so timeouts occur
      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom_range(1) == 0) ? 1 : 0,
               ($urandom_range(24) == 0) ? 1 : 0,
               ($urandom_range(39) == 0) ? 1 : 0,
               ($urandom_range(39) == 0) ? 1 : 0,
               int'($urandom_range(23)), int'($urandom_range(59)),
               int'($urandom_range(59)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
